// File: rtl/ray_job_dispatcher_if.sv
// Bundles the job, step-controller and result channels of the ray job dispatcher.
// The master side is the dispatcher; the slave side is its surrounding environment.
interface ray_job_dispatcher_if #(
  parameter int X_BITS           = 5,
  parameter int Y_BITS           = 5,
  parameter int Z_BITS           = 5,
  parameter int TIMER_WIDTH      = 32,
  parameter int STEP_COUNT_WIDTH = 16,
  parameter int TAG_BITS         = 8
);
  // Upstream job channel
  logic                        in_valid;
  logic                        in_ready;
  logic [X_BITS-1:0]           in_x;
  logic [Y_BITS-1:0]           in_y;
  logic [Z_BITS-1:0]           in_z;
  logic [TIMER_WIDTH-1:0]      in_timer_x;
  logic [TIMER_WIDTH-1:0]      in_timer_y;
  logic [TIMER_WIDTH-1:0]      in_timer_z;
  logic [STEP_COUNT_WIDTH-1:0] in_max_steps;

  // Step controller channel
  logic                        job_loaded;
  logic                        fsm_ready;
  logic [X_BITS-1:0]           job_init_x;
  logic [Y_BITS-1:0]           job_init_y;
  logic [Z_BITS-1:0]           job_init_z;
  logic [TIMER_WIDTH-1:0]      job_timer_x;
  logic [TIMER_WIDTH-1:0]      job_timer_y;
  logic [TIMER_WIDTH-1:0]      job_timer_z;
  logic [STEP_COUNT_WIDTH-1:0] max_steps;
  logic                        fsm_done;
  logic                        fsm_hit;
  logic                        fsm_timeout;
  logic [X_BITS-1:0]           fsm_hit_x;
  logic [Y_BITS-1:0]           fsm_hit_y;
  logic [Z_BITS-1:0]           fsm_hit_z;
  logic [2:0]                  fsm_face_id;
  logic [STEP_COUNT_WIDTH-1:0] fsm_steps_taken;

  // Downstream result channel
  logic                        res_valid;
  logic                        res_ready;
  logic [TAG_BITS-1:0]         res_tag;
  logic                        res_hit;
  logic                        res_timeout;
  logic                        res_miss;
  logic                        res_abort;
  logic [X_BITS-1:0]           res_x;
  logic [Y_BITS-1:0]           res_y;
  logic [Z_BITS-1:0]           res_z;
  logic [2:0]                  res_face;
  logic [STEP_COUNT_WIDTH-1:0] res_steps;

  // Status
  logic                        busy;
  logic [15:0]                 jobs_completed;

  modport master (
    input  in_valid, in_x, in_y, in_z, in_timer_x, in_timer_y, in_timer_z, in_max_steps,
    output in_ready,
    input  fsm_ready, fsm_done, fsm_hit, fsm_timeout, fsm_hit_x, fsm_hit_y, fsm_hit_z,
    input  fsm_face_id, fsm_steps_taken,
    output job_loaded, job_init_x, job_init_y, job_init_z,
    output job_timer_x, job_timer_y, job_timer_z, max_steps,
    input  res_ready,
    output res_valid, res_tag, res_hit, res_timeout, res_miss, res_abort,
    output res_x, res_y, res_z, res_face, res_steps,
    output busy, jobs_completed
  );

  modport slave (
    output in_valid, in_x, in_y, in_z, in_timer_x, in_timer_y, in_timer_z, in_max_steps,
    input  in_ready,
    output fsm_ready, fsm_done, fsm_hit, fsm_timeout, fsm_hit_x, fsm_hit_y, fsm_hit_z,
    output fsm_face_id, fsm_steps_taken,
    input  job_loaded, job_init_x, job_init_y, job_init_z,
    input  job_timer_x, job_timer_y, job_timer_z, max_steps,
    output res_ready,
    input  res_valid, res_tag, res_hit, res_timeout, res_miss, res_abort,
    input  res_x, res_y, res_z, res_face, res_steps,
    input  busy, jobs_completed
  );
endinterface

// File: rtl/ray_job_dispatcher.sv
// Accepts one ray-march job at a time, hands it to the voxel step controller,
// guards the controller with a watchdog and returns a tagged result downstream.
module ray_job_dispatcher #(
  parameter int X_BITS           = 5,
  parameter int Y_BITS           = 5,
  parameter int Z_BITS           = 5,
  parameter int TIMER_WIDTH      = 32,
  parameter int STEP_COUNT_WIDTH = 16,
  parameter int TAG_BITS         = 8,
  parameter int WATCHDOG_CYCLES  = 65535
) (
  input  logic              clock,
  input  logic              reset,
  ray_job_dispatcher_if.master bus
);

  localparam int WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESULT
  } state_e;

  state_e                      state_q;
  logic [TAG_BITS-1:0]         tag_cnt_q;
  logic [WD_W-1:0]             wd_cnt_q;
  logic [15:0]                 completed_q;

  logic [X_BITS-1:0]           job_x_q;
  logic [Y_BITS-1:0]           job_y_q;
  logic [Z_BITS-1:0]           job_z_q;
  logic [TIMER_WIDTH-1:0]      job_tx_q;
  logic [TIMER_WIDTH-1:0]      job_ty_q;
  logic [TIMER_WIDTH-1:0]      job_tz_q;
  logic [STEP_COUNT_WIDTH-1:0] job_steps_q;

  logic [TAG_BITS-1:0]         res_tag_q;
  logic                        res_hit_q;
  logic                        res_timeout_q;
  logic                        res_miss_q;
  logic                        res_abort_q;
  logic [X_BITS-1:0]           res_x_q;
  logic [Y_BITS-1:0]           res_y_q;
  logic [Z_BITS-1:0]           res_z_q;
  logic [2:0]                  res_face_q;
  logic [STEP_COUNT_WIDTH-1:0] res_steps_q;

  logic wd_expired;

  assign wd_expired = (wd_cnt_q == WD_LAST);

  // NOTE: in_ready is gated by the reset pin so upstream never sees it while reset is held.
  assign bus.in_ready       = reset && (state_q == S_IDLE);
  assign bus.job_loaded     = (state_q == S_ISSUE) && bus.fsm_ready;
  assign bus.res_valid      = (state_q == S_RESULT);
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.jobs_completed = completed_q;

  assign bus.job_init_x  = job_x_q;
  assign bus.job_init_y  = job_y_q;
  assign bus.job_init_z  = job_z_q;
  assign bus.job_timer_x = job_tx_q;
  assign bus.job_timer_y = job_ty_q;
  assign bus.job_timer_z = job_tz_q;
  assign bus.max_steps   = job_steps_q;

  assign bus.res_tag     = res_tag_q;
  assign bus.res_hit     = res_hit_q;
  assign bus.res_timeout = res_timeout_q;
  assign bus.res_miss    = res_miss_q;
  assign bus.res_abort   = res_abort_q;
  assign bus.res_x       = res_x_q;
  assign bus.res_y       = res_y_q;
  assign bus.res_z       = res_z_q;
  assign bus.res_face    = res_face_q;
  assign bus.res_steps   = res_steps_q;

  // NOTE: every register here is small control/data state, so all of it takes the
  // asynchronous reset and is updated only with non-blocking assignments.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      tag_cnt_q     <= '0;
      wd_cnt_q      <= '0;
      completed_q   <= '0;
      job_x_q       <= '0;
      job_y_q       <= '0;
      job_z_q       <= '0;
      job_tx_q      <= '0;
      job_ty_q      <= '0;
      job_tz_q      <= '0;
      job_steps_q   <= '0;
      res_tag_q     <= '0;
      res_hit_q     <= 1'b0;
      res_timeout_q <= 1'b0;
      res_miss_q    <= 1'b0;
      res_abort_q   <= 1'b0;
      res_x_q       <= '0;
      res_y_q       <= '0;
      res_z_q       <= '0;
      res_face_q    <= '0;
      res_steps_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            job_x_q     <= bus.in_x;
            job_y_q     <= bus.in_y;
            job_z_q     <= bus.in_z;
            job_tx_q    <= bus.in_timer_x;
            job_ty_q    <= bus.in_timer_y;
            job_tz_q    <= bus.in_timer_z;
            job_steps_q <= bus.in_max_steps;
            res_tag_q   <= tag_cnt_q;
            tag_cnt_q   <= tag_cnt_q + 1'b1;
            state_q     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (bus.fsm_ready) begin
            wd_cnt_q <= '0;
            state_q  <= S_WAIT;
          end
        end

        S_WAIT: begin
          // A done arriving on the watchdog's last cycle still counts as a real result.
          if (bus.fsm_done) begin
            res_hit_q     <= bus.fsm_hit;
            res_timeout_q <= bus.fsm_timeout;
            res_miss_q    <= !bus.fsm_hit && !bus.fsm_timeout;
            res_abort_q   <= 1'b0;
            res_x_q       <= bus.fsm_hit ? bus.fsm_hit_x   : '0;
            res_y_q       <= bus.fsm_hit ? bus.fsm_hit_y   : '0;
            res_z_q       <= bus.fsm_hit ? bus.fsm_hit_z   : '0;
            res_face_q    <= bus.fsm_hit ? bus.fsm_face_id : '0;
            res_steps_q   <= bus.fsm_steps_taken;
            state_q       <= S_RESULT;
          end else if (wd_expired) begin
            res_hit_q     <= 1'b0;
            res_timeout_q <= 1'b0;
            res_miss_q    <= 1'b0;
            res_abort_q   <= 1'b1;
            res_x_q       <= '0;
            res_y_q       <= '0;
            res_z_q       <= '0;
            res_face_q    <= '0;
            res_steps_q   <= '0;
            state_q       <= S_RESULT;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end

        S_RESULT: begin
          if (bus.res_ready) begin
            completed_q <= completed_q + 16'd1;
            state_q     <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Protocol invariants the surrounding blocks rely on.
  a_job_held : assert property (@(posedge clock) disable iff (!reset)
    (state_q != S_IDLE) |=> $stable({job_x_q, job_y_q, job_z_q, job_tx_q, job_ty_q,
                                     job_tz_q, job_steps_q}));

  a_res_held : assert property (@(posedge clock) disable iff (!reset)
    (bus.res_valid && !bus.res_ready) |=> (bus.res_valid &&
      $stable({res_tag_q, res_hit_q, res_timeout_q, res_miss_q, res_abort_q,
               res_x_q, res_y_q, res_z_q, res_face_q, res_steps_q})));

  a_one_side : assert property (@(posedge clock) disable iff (!reset)
    !(bus.in_ready && (bus.res_valid || bus.job_loaded)));

endmodule

// File: tb/tb_ray_job_dispatcher.sv
// Scenario bench for ray_job_dispatcher: a result scoreboard plus per-scenario
// timing and stability checks.
module tb_ray_job_dispatcher;

  localparam int WD = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  ray_job_dispatcher_if #(
    .X_BITS(5), .Y_BITS(5), .Z_BITS(5), .TIMER_WIDTH(32), .STEP_COUNT_WIDTH(16), .TAG_BITS(8)
  ) bus ();

  ray_job_dispatcher #(
    .X_BITS(5), .Y_BITS(5), .Z_BITS(5), .TIMER_WIDTH(32), .STEP_COUNT_WIDTH(16),
    .TAG_BITS(8), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [7:0]  tag;
    logic        hit;
    logic        timeout;
    logic        miss;
    logic        abort;
    logic [4:0]  x;
    logic [4:0]  y;
    logic [4:0]  z;
    logic [2:0]  face;
    logic [15:0] steps;
  } res_t;

  res_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] next_tag = 8'd0;

  function automatic res_t mk_res(input logic [7:0] tag, input logic hit, input logic timeout,
                                  input logic abort, input logic [4:0] x, input logic [4:0] y,
                                  input logic [4:0] z, input logic [2:0] face,
                                  input logic [15:0] steps);
    res_t r;
    r     = '0;
    r.tag = tag;
    if (abort) begin
      r.abort = 1'b1;
      return r;
    end
    r.hit     = hit;
    r.timeout = timeout;
    r.miss    = !hit && !timeout;
    if (hit) begin
      r.x    = x;
      r.y    = y;
      r.z    = z;
      r.face = face;
    end
    r.steps = steps;
    return r;
  endfunction

  function automatic res_t observed_res();
    res_t r;
    r.tag     = bus.res_tag;
    r.hit     = bus.res_hit;
    r.timeout = bus.res_timeout;
    r.miss    = bus.res_miss;
    r.abort   = bus.res_abort;
    r.x       = bus.res_x;
    r.y       = bus.res_y;
    r.z       = bus.res_z;
    r.face    = bus.res_face;
    r.steps   = bus.res_steps;
    return r;
  endfunction

  // Scoreboard: every consumed result must match the oldest expectation.
  always @(negedge clock) begin
    res_t e;
    if (reset && bus.res_valid && bus.res_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got %h, required no result", observed_res());
      end else begin
        e = exp_q.pop_front();
        if (observed_res() !== e) begin
          n_fail++;
          $display("FAIL result_fields: got %h, required %h", observed_res(), e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish within 500000 ns");
    $fatal(1, "simulation time limit reached");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid        = 1'b0;
    bus.in_x            = '0;
    bus.in_y            = '0;
    bus.in_z            = '0;
    bus.in_timer_x      = '0;
    bus.in_timer_y      = '0;
    bus.in_timer_z      = '0;
    bus.in_max_steps    = '0;
    bus.fsm_done        = 1'b0;
    bus.fsm_hit         = 1'b0;
    bus.fsm_timeout     = 1'b0;
    bus.fsm_hit_x       = '0;
    bus.fsm_hit_y       = '0;
    bus.fsm_hit_z       = '0;
    bus.fsm_face_id     = '0;
    bus.fsm_steps_taken = '0;
  endtask

  task automatic drive_done(input logic hit, input logic timeout, input logic [4:0] x,
                            input logic [4:0] y, input logic [4:0] z, input logic [2:0] face,
                            input logic [15:0] steps);
    bus.fsm_done        = 1'b1;
    bus.fsm_hit         = hit;
    bus.fsm_timeout     = timeout;
    bus.fsm_hit_x       = x;
    bus.fsm_hit_y       = y;
    bus.fsm_hit_z       = z;
    bus.fsm_face_id     = face;
    bus.fsm_steps_taken = steps;
  endtask

  // Presents a job and returns one cycle after the accepting edge (ISSUE cycle).
  task automatic send_job(input logic [4:0] x, input logic [4:0] y, input logic [4:0] z,
                          input logic [31:0] tx, input logic [31:0] ty, input logic [31:0] tz,
                          input logic [15:0] ms, output logic [7:0] tag);
    logic ok;
    ok               = 1'b0;
    bus.in_valid     = 1'b1;
    bus.in_x         = x;
    bus.in_y         = y;
    bus.in_z         = z;
    bus.in_timer_x   = tx;
    bus.in_timer_y   = ty;
    bus.in_timer_z   = tz;
    bus.in_max_steps = ms;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = bus.in_ready;
      step();
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, required 1");
    end
    tag      = next_tag;
    next_tag = next_tag + 8'd1;
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (bus.in_ready) ok = 1'b1;
      else step();
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: got in_ready=0, required 1 within 100 cycles", name);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.fsm_ready = 1'b1;
    bus.res_ready = 1'b1;
    reset         = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({bus.in_ready, bus.job_loaded, bus.res_valid, bus.busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy/ld/val/busy=%b, required 0000",
               {bus.in_ready, bus.job_loaded, bus.res_valid, bus.busy});
    end
    n_checks++;
    if ({bus.jobs_completed, bus.res_tag, bus.job_init_x, bus.max_steps} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: got cnt=%0d tag=%0d x=%0d ms=%0d, required all 0",
               bus.jobs_completed, bus.res_tag, bus.job_init_x, bus.max_steps);
    end
    reset    = 1'b1;
    next_tag = 8'd0;
    step();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_hit();
    logic [7:0] tag;
    send_job(5'd1, 5'd2, 5'd3, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 16'd100, tag);
    n_checks++;
    if (bus.job_loaded !== 1'b1) begin
      n_fail++;
      $display("FAIL hit_job_loaded: got %b, required 1", bus.job_loaded);
    end
    n_checks++;
    if ({bus.job_init_x, bus.job_init_y, bus.job_init_z, bus.job_timer_x, bus.job_timer_z,
         bus.max_steps} !== {5'd1, 5'd2, 5'd3, 32'h0001_0000, 32'h0003_0000, 16'd100}) begin
      n_fail++;
      $display("FAIL hit_job_fields: got x=%0d y=%0d z=%0d ms=%0d, required 1 2 3 100",
               bus.job_init_x, bus.job_init_y, bus.job_init_z, bus.max_steps);
    end
    step();
    n_checks++;
    if (bus.job_loaded !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_pulse_width: got job_loaded=%b in WAIT, required 0", bus.job_loaded);
    end
    step();
    drive_done(1'b1, 1'b0, 5'd4, 5'd2, 5'd3, 3'b001, 16'd3);
    exp_q.push_back(mk_res(tag, 1'b1, 1'b0, 1'b0, 5'd4, 5'd2, 5'd3, 3'b001, 16'd3));
    step();
    bus.fsm_done = 1'b0;
    n_checks++;
    if ({bus.res_valid, bus.res_tag, bus.res_hit, bus.res_x, bus.res_y, bus.res_z, bus.res_face}
        !== {1'b1, 8'd0, 1'b1, 5'd4, 5'd2, 5'd3, 3'b001}) begin
      n_fail++;
      $display("FAIL hit_result: got val=%b tag=%0d hit=%b xyz=%0d,%0d,%0d face=%b, required 1 0 1 4,2,3 001",
               bus.res_valid, bus.res_tag, bus.res_hit, bus.res_x, bus.res_y, bus.res_z, bus.res_face);
    end
    step();
    n_checks++;
    if ({bus.in_ready, bus.jobs_completed} !== {1'b1, 16'd1}) begin
      n_fail++;
      $display("FAIL hit_complete: got rdy=%b cnt=%0d, required 1 1", bus.in_ready, bus.jobs_completed);
    end
  endtask

  task automatic test_stall();
    logic [7:0] tag;
    bus.fsm_ready = 1'b0;
    send_job(5'd7, 5'd8, 5'd9, 32'h11, 32'h22, 32'h33, 16'd50, tag);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) drive_done(1'b1, 1'b0, 5'd1, 5'd1, 5'd1, 3'b010, 16'd1);
      n_checks++;
      if ({bus.job_loaded, bus.busy, bus.res_valid, bus.job_init_x, bus.job_init_y,
           bus.job_init_z, bus.job_timer_y, bus.max_steps}
          !== {1'b0, 1'b1, 1'b0, 5'd7, 5'd8, 5'd9, 32'h22, 16'd50}) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: got ld=%b busy=%b val=%b x=%0d ms=%0d, required 0 1 0 7 50",
                 i, bus.job_loaded, bus.busy, bus.res_valid, bus.job_init_x, bus.max_steps);
      end
      step();
    end
    idle_inputs();
    bus.fsm_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.job_loaded !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got job_loaded=%b, required 1", bus.job_loaded);
    end
    step();
    n_checks++;
    if ({bus.job_loaded, bus.job_init_x, bus.job_init_z, bus.max_steps}
        !== {1'b0, 5'd7, 5'd9, 16'd50}) begin
      n_fail++;
      $display("FAIL stall_single_pulse: got ld=%b x=%0d z=%0d ms=%0d, required 0 7 9 50",
               bus.job_loaded, bus.job_init_x, bus.job_init_z, bus.max_steps);
    end
    drive_done(1'b0, 1'b0, 5'd17, 5'd5, 5'd6, 3'b101, 16'd50);
    exp_q.push_back(mk_res(tag, 1'b0, 1'b0, 1'b0, 5'd17, 5'd5, 5'd6, 3'b101, 16'd50));
    step();
    bus.fsm_done = 1'b0;
    n_checks++;
    if ({bus.res_miss, bus.res_hit, bus.res_x, bus.res_face} !== {1'b1, 1'b0, 5'd0, 3'd0}) begin
      n_fail++;
      $display("FAIL stall_miss: got miss=%b hit=%b x=%0d face=%b, required 1 0 0 000",
               bus.res_miss, bus.res_hit, bus.res_x, bus.res_face);
    end
    step();
    wait_idle("stall");
  endtask

  task automatic test_backpressure();
    logic [7:0] tag_a;
    logic [7:0] tag_b;
    res_t       exp_a;
    bus.res_ready = 1'b0;
    send_job(5'd10, 5'd11, 5'd12, 32'hA, 32'hB, 32'hC, 16'd200, tag_a);
    step();
    drive_done(1'b0, 1'b1, 5'd3, 5'd3, 5'd3, 3'b011, 16'd200);
    exp_a = mk_res(tag_a, 1'b0, 1'b1, 1'b0, 5'd3, 5'd3, 5'd3, 3'b011, 16'd200);
    exp_q.push_back(exp_a);
    bus.in_valid     = 1'b1;
    bus.in_x         = 5'd21;
    bus.in_y         = 5'd22;
    bus.in_z         = 5'd23;
    bus.in_max_steps = 16'd300;
    step();
    bus.fsm_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({bus.res_valid, bus.in_ready, observed_res(), bus.job_init_x}
          !== {1'b1, 1'b0, exp_a, 5'd10}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got val=%b rdy=%b res=%h x=%0d, required 1 0 %h 10",
                 i, bus.res_valid, bus.in_ready, observed_res(), bus.job_init_x, exp_a);
      end
      step();
    end
    bus.res_ready = 1'b1;
    step();
    n_checks++;
    if ({bus.in_ready, bus.res_valid, bus.jobs_completed} !== {1'b1, 1'b0, 16'd3}) begin
      n_fail++;
      $display("FAIL bp_handshake: got rdy=%b val=%b cnt=%0d, required 1 0 3",
               bus.in_ready, bus.res_valid, bus.jobs_completed);
    end
    step();
    bus.in_valid = 1'b0;
    tag_b        = next_tag;
    next_tag     = next_tag + 8'd1;
    n_checks++;
    if ({bus.job_init_x, bus.job_init_y, bus.job_init_z, bus.max_steps, bus.job_loaded}
        !== {5'd21, 5'd22, 5'd23, 16'd300, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_next_job: got x=%0d y=%0d z=%0d ms=%0d ld=%b, required 21 22 23 300 1",
               bus.job_init_x, bus.job_init_y, bus.job_init_z, bus.max_steps, bus.job_loaded);
    end
    step();
    drive_done(1'b1, 1'b0, 5'd1, 5'd1, 5'd1, 3'b100, 16'd12);
    exp_q.push_back(mk_res(tag_b, 1'b1, 1'b0, 1'b0, 5'd1, 5'd1, 5'd1, 3'b100, 16'd12));
    step();
    bus.fsm_done = 1'b0;
    step();
    wait_idle("bp");
  endtask

  task automatic test_watchdog();
    logic [7:0] tag;
    send_job(5'd3, 5'd3, 5'd3, 32'h1, 32'h1, 32'h1, 16'd9, tag);
    step();
    exp_q.push_back(mk_res(tag, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 3'd0, 16'd0));
    for (int i = 0; i < WD; i++) begin
      n_checks++;
      if ({bus.res_valid, bus.busy} !== 2'b01) begin
        n_fail++;
        $display("FAIL wd_wait%0d: got val/busy=%b, required 01", i, {bus.res_valid, bus.busy});
      end
      step();
    end
    n_checks++;
    if ({bus.res_valid, bus.res_abort, bus.res_miss} !== 3'b110) begin
      n_fail++;
      $display("FAIL wd_abort: got val/abort/miss=%b, required 110",
               {bus.res_valid, bus.res_abort, bus.res_miss});
    end
    step();
    drive_done(1'b1, 1'b0, 5'd8, 5'd8, 5'd8, 3'b001, 16'd4);
    step();
    bus.fsm_done = 1'b0;
    n_checks++;
    if ({bus.busy, bus.res_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL wd_late_done: got busy/val=%b, required 00", {bus.busy, bus.res_valid});
    end
    repeat (3) step();
    n_checks++;
    if (bus.jobs_completed !== 16'd5) begin
      n_fail++;
      $display("FAIL wd_count: got %0d, required 5", bus.jobs_completed);
    end
    // Done on the watchdog's last cycle must win over the abort.
    send_job(5'd9, 5'd9, 5'd9, 32'h2, 32'h2, 32'h2, 16'd15, tag);
    step();
    for (int i = 0; i < WD - 1; i++) step();
    drive_done(1'b1, 1'b0, 5'd9, 5'd9, 5'd9, 3'b010, 16'd15);
    exp_q.push_back(mk_res(tag, 1'b1, 1'b0, 1'b0, 5'd9, 5'd9, 5'd9, 3'b010, 16'd15));
    step();
    bus.fsm_done = 1'b0;
    n_checks++;
    if ({bus.res_valid, bus.res_abort, bus.res_hit} !== 3'b101) begin
      n_fail++;
      $display("FAIL wd_done_wins: got val/abort/hit=%b, required 101",
               {bus.res_valid, bus.res_abort, bus.res_hit});
    end
    step();
    wait_idle("wd");
  endtask

  task automatic test_reset_mid_wait();
    logic [7:0] tag;
    send_job(5'd15, 5'd16, 5'd17, 32'h5, 32'h6, 32'h7, 16'd77, tag);
    step();
    step();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.res_valid, bus.in_ready, bus.jobs_completed, bus.job_init_x}
        !== {1'b0, 1'b0, 1'b0, 16'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL rst_mid_state: got busy=%b val=%b rdy=%b cnt=%0d x=%0d, required 0 0 0 0 0",
               bus.busy, bus.res_valid, bus.in_ready, bus.jobs_completed, bus.job_init_x);
    end
    next_tag = 8'd0;
    step();
    reset = 1'b1;
    drive_done(1'b1, 1'b0, 5'd15, 5'd16, 5'd17, 3'b001, 16'd2);
    step();
    bus.fsm_done = 1'b0;
    n_checks++;
    if ({bus.busy, bus.res_valid, bus.in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL rst_late_done: got busy/val/rdy=%b, required 001",
               {bus.busy, bus.res_valid, bus.in_ready});
    end
    send_job(5'd2, 5'd4, 5'd6, 32'h8, 32'h9, 32'hA, 16'd20, tag);
    step();
    drive_done(1'b1, 1'b0, 5'd2, 5'd4, 5'd6, 3'b011, 16'd5);
    exp_q.push_back(mk_res(tag, 1'b1, 1'b0, 1'b0, 5'd2, 5'd4, 5'd6, 3'b011, 16'd5));
    step();
    bus.fsm_done = 1'b0;
    n_checks++;
    if ({bus.res_valid, bus.res_tag} !== {1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL rst_first_tag: got val=%b tag=%0d, required 1 0", bus.res_valid, bus.res_tag);
    end
    step();
    n_checks++;
    if (bus.jobs_completed !== 16'd1) begin
      n_fail++;
      $display("FAIL rst_count: got %0d, required 1", bus.jobs_completed);
    end
  endtask

  task automatic test_tag_wrap();
    logic [7:0] tag;
    reset = 1'b0;
    step();
    reset    = 1'b1;
    next_tag = 8'd0;
    step();
    for (int j = 0; j < 257; j++) begin
      send_job(j[4:0], j[5:1], j[6:2], 32'(j), 32'(j + 1), 32'(j + 2), j[15:0], tag);
      step();
      drive_done(1'b0, 1'b0, j[4:0], 5'd1, 5'd2, 3'b110, j[15:0]);
      exp_q.push_back(mk_res(8'(j % 256), 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'd0, j[15:0]));
      step();
      bus.fsm_done = 1'b0;
      step();
    end
    n_checks++;
    if (bus.jobs_completed !== 16'd257) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d, required 257", bus.jobs_completed);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_stall();
    test_backpressure();
    test_watchdog();
    test_reset_mid_wait();
    test_tag_wrap();
    repeat (5) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d outstanding results, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
